// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, constants and GF(2^8) helpers
package aes_pkg;
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;
  typedef enum logic {FULL_G = 1'b0, SUB_ONLY = 1'b1} mode_e;
  localparam logic [7:0] RCON_INIT = 8'h01;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_SubByte.sv
// aes_SubByte: combinational AES forward S-box for one byte
module aes_SubByte (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign dout = SBOX[din];
endmodule

// File: rtl/aes_key_g_unit.sv
// aes_key_g_unit: AES key-expansion g() step with time-multiplexed S-box lanes and an Rcon register
module aes_key_g_unit
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4,
  parameter int BEATS    = 4 / NUM_SBOX
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] word_i,
  input  logic        mode_i,
  input  logic        rcon_clr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] word_o,
  output logic [7:0]  rcon_o
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  state_e        state_q;
  mode_e         mode_q;
  logic [BW-1:0] beat_q;
  logic [31:0]   data_q, data_sub;
  logic [7:0]    rcap_q, rcon_q;
  logic [7:0]    sb_out [NUM_SBOX];
  logic          last_beat;
  assign last_beat = beat_q == BW'(BEATS - 1);
  assign word_o    = valid_o ? data_q : '0;
  assign rcon_o    = rcon_q;
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
    aes_SubByte u_sbox (
      .din  (data_q[(int'(beat_q) * NUM_SBOX + g) * 8 +: 8]),
      .dout (sb_out[g])
    );
  end
  // Merge this beat's substituted bytes back into the working word
  always_comb begin
    data_sub = data_q;
    for (int l = 0; l < NUM_SBOX; l++) data_sub[(int'(beat_q) * NUM_SBOX + l) * 8 +: 8] = sb_out[l];
  end
  // Handshake FSM, working word, beat counter and Rcon register
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= FULL_G;
      beat_q  <= '0;
      data_q  <= '0;
      rcap_q  <= RCON_INIT;
      rcon_q  <= RCON_INIT;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      rcon_q <= rcon_clr_i ? RCON_INIT :
                (state_q == DONE && ready_i && mode_q == FULL_G) ? xtime(rcon_q) : rcon_q;
      unique case (state_q)
        IDLE: if (valid_i) begin
          data_q  <= mode_i ? word_i : {word_i[23:0], word_i[31:24]};
          mode_q  <= mode_e'(mode_i);
          rcap_q  <= rcon_q;
          beat_q  <= '0;
          state_q <= SUB;
          ready_o <= 1'b0;
        end
        SUB: begin
          data_q  <= data_sub ^ ((last_beat && mode_q == FULL_G) ? {rcap_q, 24'h0} : 32'h0);
          beat_q  <= last_beat ? '0 : beat_q + 1'b1;
          state_q <= last_beat ? DONE : SUB;
          valid_o <= last_beat;
        end
        DONE: if (ready_i) begin
          state_q <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_g_unit.sv
// tb_aes_key_g_unit: checks three lane configurations against a GF(2^8) reference model
module tb_aes_key_g_unit;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic        rst_n [3], valid_i [3], mode_i [3], rcon_clr_i [3], ready_i [3], ready_o [3], valid_o [3];
  logic [31:0] word_i [3], word_o [3];
  logic [7:0]  rcon_o [3];
  logic [7:0]  sbox [256];
  logic [7:0]  exp_rcon [3];
  logic [7:0]  rseq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int          beats [3] = '{1, 4, 2};
  int          checks = 0;
  int          failures = 0;

  aes_key_g_unit #(.NUM_SBOX(4)) u_dut4 (
    .clk_i(clk_i), .rst_n(rst_n[0]), .valid_i(valid_i[0]), .ready_o(ready_o[0]), .word_i(word_i[0]),
    .mode_i(mode_i[0]), .rcon_clr_i(rcon_clr_i[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .word_o(word_o[0]), .rcon_o(rcon_o[0]));
  aes_key_g_unit #(.NUM_SBOX(1)) u_dut1 (
    .clk_i(clk_i), .rst_n(rst_n[1]), .valid_i(valid_i[1]), .ready_o(ready_o[1]), .word_i(word_i[1]),
    .mode_i(mode_i[1]), .rcon_clr_i(rcon_clr_i[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .word_o(word_o[1]), .rcon_o(rcon_o[1]));
  aes_key_g_unit #(.NUM_SBOX(2)) u_dut2 (
    .clk_i(clk_i), .rst_n(rst_n[2]), .valid_i(valid_i[2]), .ready_o(ready_o[2]), .word_i(word_i[2]),
    .mode_i(mode_i[2]), .rcon_clr_i(rcon_clr_i[2]), .valid_o(valid_o[2]), .ready_i(ready_i[2]),
    .word_o(word_o[2]), .rcon_o(rcon_o[2]));

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] g_ref(logic [31:0] w, logic m, logic [7:0] rc);
    logic [31:0] t = m ? w : {w[23:0], w[31:24]};
    logic [31:0] s;
    for (int i = 0; i < 4; i++) s[i*8 +: 8] = sbox[t[i*8 +: 8]];
    return m ? s : s ^ {rc, 24'h0};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_word(int k, logic [31:0] w, logic m, int hold, logic clr_hs, logic poke, output logic [31:0] got);
    logic [31:0] exp_w;
    int n;
    exp_w = g_ref(w, m, exp_rcon[k]);
    n = 0;
    while (!ready_o[k] && n < 20) begin tick(); n++; end
    check("ready_before_accept", 32'(ready_o[k]), 32'd1);
    valid_i[k] = 1'b1; word_i[k] = w; mode_i[k] = m;
    tick();
    valid_i[k] = poke; word_i[k] = $urandom; mode_i[k] = 1'($urandom);
    check("ready_low_after_accept", 32'(ready_o[k]), 32'd0);
    n = 0;
    while (!valid_o[k] && n < 20) begin tick(); n++; end
    check("latency", 32'(n), 32'(beats[k]));
    check("word", word_o[k], exp_w);
    got = word_o[k];
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(valid_o[k]), 32'd1);
      check("hold_word", word_o[k], exp_w);
      check("hold_ready", 32'(ready_o[k]), 32'd0);
    end
    valid_i[k] = 1'b0; ready_i[k] = 1'b1; rcon_clr_i[k] = clr_hs;
    tick();
    ready_i[k] = 1'b0; rcon_clr_i[k] = 1'b0;
    if (clr_hs) exp_rcon[k] = 8'h01;
    else if (!m) exp_rcon[k] = gmul(exp_rcon[k], 8'h02);
    check("valid_after_hs", 32'(valid_o[k]), 32'd0);
    check("word_after_hs", word_o[k], 32'd0);
    check("ready_after_hs", 32'(ready_o[k]), 32'd1);
    check("rcon_after_hs", 32'(rcon_o[k]), 32'(exp_rcon[k]));
  endtask

  initial begin
    logic [31:0] got;
    logic [7:0] inv, b;
    int n;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; valid_i[k] = 1'b0; word_i[k] = '0; mode_i[k] = 1'b0;
      rcon_clr_i[k] = 1'b0; ready_i[k] = 1'b0; exp_rcon[k] = 8'h01;
    end
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", 32'(ready_o[k]), 32'd1);
      check("reset_valid", 32'(valid_o[k]), 32'd0);
      check("reset_word", word_o[k], 32'd0);
      check("reset_rcon", 32'(rcon_o[k]), 32'h01);
      rst_n[k] = 1'b1;
    end
    tick();
    do_word(0, 32'h09CF4F3C, 1'b0, 0, 1'b0, 1'b0, got);
    check("fips_word", got, 32'h8B84EB01);
    check("fips_rcon", 32'(rcon_o[0]), 32'h02);
    do_word(1, 32'h0, 1'b1, 0, 1'b0, 1'b0, got);
    check("subonly_word", got, 32'h63636363);
    check("subonly_rcon", 32'(rcon_o[1]), 32'h01);
    rcon_clr_i[0] = 1'b1;
    tick();
    rcon_clr_i[0] = 1'b0;
    exp_rcon[0] = 8'h01;
    for (int i = 0; i < 10; i++) begin
      check("rcon_seq", 32'(rcon_o[0]), 32'(rseq[i]));
      do_word(0, $urandom, 1'b0, 0, 1'b0, 1'b0, got);
    end
    do_word(2, $urandom, 1'($urandom), 5, 1'b0, 1'b1, got);
    do_word(1, $urandom, 1'b0, 5, 1'b0, 1'b1, got);
    do_word(0, $urandom, 1'b0, 1, 1'b1, 1'b0, got);
    check("clr_vs_advance", 32'(rcon_o[0]), 32'h01);
    valid_i[2] = 1'b1; word_i[2] = $urandom; mode_i[2] = 1'b0;
    tick();
    valid_i[2] = 1'b0;
    tick();
    rst_n[2] = 1'b0;
    tick();
    check("midsub_reset_ready", 32'(ready_o[2]), 32'd1);
    check("midsub_reset_valid", 32'(valid_o[2]), 32'd0);
    check("midsub_reset_word", word_o[2], 32'd0);
    check("midsub_reset_rcon", 32'(rcon_o[2]), 32'h01);
    rst_n[2] = 1'b1;
    exp_rcon[2] = 8'h01;
    n = 0;
    repeat (8) begin tick(); if (valid_o[2]) n++; end
    check("no_result_after_reset", 32'(n), 32'd0);
    repeat (30) do_word($urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                        1'b0, 1'($urandom_range(0, 1)), got);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
